register_dirty_encoder: RTL and testbench

- Companion to the register-file write-select decoder. Consumes the same 32-bit one-hot write-select vector and write enable, and records which architectural registers have been written (dirty set).
- On request, scans the dirty set and re-encodes it into a stream of 5-bit register indices, lowest first, over a valid/ready handshake.
- Used for context save and debug dump: the downstream reader fetches each offered register through a register-file read port.

---
 rtl/register_dirty_encoder.sv | 170 +++++++++++++++++
 tb/tb_register_dirty_encoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_dirty_encoder.sv
// register_dirty_encoder: tracks which architectural registers have been
// written (dirty set) from the one-hot write-select vector, and on request
// streams the dirty indices out lowest-first over a valid/ready handshake.
module register_dirty_encoder #(
  parameter int N_REGS      = 32,
  parameter int INDEX_WIDTH = 5,
  parameter int MASK_ZERO   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write_enable_i,
  input  logic [N_REGS-1:0]      select_register_i,
  input  logic                   clear_all_i,
  input  logic                   scan_start_i,
  output logic [INDEX_WIDTH-1:0] index_o,
  output logic                   index_valid_o,
  input  logic                   index_ready_i,
  output logic                   scan_busy_o,
  output logic                   scan_done_o,
  output logic [N_REGS-1:0]      dirty_o,
  output logic                   onehot_error_o
);

  // Pointer is one bit wider than an index so last-index+1 does not wrap.
  localparam int PW = INDEX_WIDTH + 1;

  // Bit 0 ($zero) is removed from the settable set when MASK_ZERO is 1.
  localparam logic [N_REGS-1:0] WRITE_MASK = {{(N_REGS-1){1'b1}}, (MASK_ZERO == 0)};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_OFFER  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [N_REGS-1:0]      dirty_q, dirty_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic [N_REGS-1:0]      at_or_above_ptr;
  logic [N_REGS-1:0]      candidates;
  logic                   found;
  logic [INDEX_WIDTH-1:0] found_idx;
  logic                   sel_onehot;
  logic                   accept;

  // A select is one-hot when it is non-zero and has only one bit set.
  assign sel_onehot = (select_register_i != '0) &&
                      ((select_register_i & (select_register_i - N_REGS'(1))) == '0);

  assign accept = (state_q == S_OFFER) && index_ready_i;

  // Per-bit window: only indices at or above the scan pointer are eligible.
  for (genvar gi = 0; gi < N_REGS; gi++) begin : g_window
    assign at_or_above_ptr[gi] = (ptr_q <= PW'(gi));
  end

  assign candidates = dirty_q & at_or_above_ptr;

  // Priority encoder: lowest eligible dirty index (iterate high to low).
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (candidates[i]) begin
        found     = 1'b1;
        found_idx = INDEX_WIDTH'(i);
      end
    end
  end

  // Dirty set and error flag next state; a same-cycle write beats the accept-clear.
  always_comb begin
    dirty_d = dirty_q;
    err_d   = err_q;
    if (clear_all_i) begin
      dirty_d = '0;
      err_d   = 1'b0;
    end else begin
      if (accept) begin
        dirty_d[index_q] = 1'b0;
      end
      if (write_enable_i) begin
        if (sel_onehot) begin
          dirty_d = dirty_d | (select_register_i & WRITE_MASK);
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Scan FSM next state, pointer and offered index.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    index_d = index_q;
    valid_d = valid_q;
    if (clear_all_i) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (scan_start_i) begin
            state_d = S_SEARCH;
            ptr_d   = '0;
          end
        end
        S_SEARCH: begin
          if (found) begin
            index_d = found_idx;
            valid_d = 1'b1;
            state_d = S_OFFER;
          end else begin
            state_d = S_DONE;
          end
        end
        S_OFFER: begin
          if (index_ready_i) begin
            valid_d = 1'b0;
            ptr_d   = {1'b0, index_q} + PW'(1);
            if (index_q == INDEX_WIDTH'(N_REGS - 1)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_SEARCH;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      dirty_q <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dirty_q <= dirty_d;
      index_q <= index_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign index_o        = index_q;
  assign index_valid_o  = valid_q;
  assign scan_busy_o    = (state_q != S_IDLE);
  assign scan_done_o    = (state_q == S_DONE);
  assign dirty_o        = dirty_q;
  assign onehot_error_o = err_q;

endmodule

// File: tb/tb_register_dirty_encoder.sv
// Directed bench for register_dirty_encoder: inputs change 1 time unit after
// a rising edge and outputs are observed at the same point.
module tb_register_dirty_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_enable_i;
  logic [31:0] select_register_i;
  logic        clear_all_i;
  logic        scan_start_i;
  logic [4:0]  index_o;
  logic        index_valid_o;
  logic        index_ready_i;
  logic        scan_busy_o;
  logic        scan_done_o;
  logic [31:0] dirty_o;
  logic        onehot_error_o;

  int tests_run = 0;
  int tests_failed = 0;

  register_dirty_encoder dut (
    .clk              (clk),
    .reset            (reset),
    .write_enable_i   (write_enable_i),
    .select_register_i(select_register_i),
    .clear_all_i      (clear_all_i),
    .scan_start_i     (scan_start_i),
    .index_o          (index_o),
    .index_valid_o    (index_valid_o),
    .index_ready_i    (index_ready_i),
    .scan_busy_o      (scan_busy_o),
    .scan_done_o      (scan_done_o),
    .dirty_o          (dirty_o),
    .onehot_error_o   (onehot_error_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [31:0] sel);
    write_enable_i    = 1'b1;
    select_register_i = sel;
    tick();
    write_enable_i    = 1'b0;
    select_register_i = '0;
  endtask

  task automatic clear_pulse();
    clear_all_i = 1'b1;
    tick();
    clear_all_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    write_enable_i = 1'b0;
    select_register_i = '0;
    clear_all_i = 1'b0;
    scan_start_i = 1'b0;
    index_ready_i = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_dirty", dirty_o, 32'h0);
    chk("rst_index", 32'(index_o), 32'd0);
    chk("rst_valid", 32'(index_valid_o), 32'd0);
    chk("rst_busy", 32'(scan_busy_o), 32'd0);
    chk("rst_done", 32'(scan_done_o), 32'd0);
    chk("rst_err", 32'(onehot_error_o), 32'd0);
    $display("[TB] reset state checked");

    // Scan of {5,31} with ready high
    write_reg(32'h0000_0020);
    write_reg(32'h8000_0000);
    chk("s1_dirty", dirty_o, 32'h8000_0020);
    scan_start_i = 1'b1;
    index_ready_i = 1'b1;
    tick();
    scan_start_i = 1'b0;
    chk("s1_t1_busy", 32'(scan_busy_o), 32'd1);
    chk("s1_t1_valid", 32'(index_valid_o), 32'd0);
    tick();
    chk("s1_t2_valid", 32'(index_valid_o), 32'd1);
    chk("s1_t2_index", 32'(index_o), 32'd5);
    $display("[TB] scan offered index %0d", index_o);
    tick();
    chk("s1_t3_valid", 32'(index_valid_o), 32'd0);
    tick();
    chk("s1_t4_valid", 32'(index_valid_o), 32'd1);
    chk("s1_t4_index", 32'(index_o), 32'd31);
    $display("[TB] scan offered index %0d", index_o);
    tick();
    chk("s1_t5_done", 32'(scan_done_o), 32'd1);
    chk("s1_t5_valid", 32'(index_valid_o), 32'd0);
    tick();
    chk("s1_t6_done", 32'(scan_done_o), 32'd0);
    chk("s1_t6_busy", 32'(scan_busy_o), 32'd0);
    chk("s1_dirty_after", dirty_o, 32'h0);

    // Empty dirty set
    scan_start_i = 1'b1;
    tick();
    scan_start_i = 1'b0;
    chk("s2_t1_busy", 32'(scan_busy_o), 32'd1);
    chk("s2_t1_done", 32'(scan_done_o), 32'd0);
    chk("s2_t1_valid", 32'(index_valid_o), 32'd0);
    tick();
    chk("s2_t2_done", 32'(scan_done_o), 32'd1);
    chk("s2_t2_busy", 32'(scan_busy_o), 32'd1);
    chk("s2_t2_valid", 32'(index_valid_o), 32'd0);
    tick();
    chk("s2_t3_done", 32'(scan_done_o), 32'd0);
    chk("s2_t3_busy", 32'(scan_busy_o), 32'd0);
    $display("[TB] empty scan checked");

    // Masked zero and non-one-hot selects
    index_ready_i = 1'b0;
    write_reg(32'h0000_0001);
    chk("s3_zero_dirty", dirty_o, 32'h0);
    chk("s3_zero_err", 32'(onehot_error_o), 32'd0);
    write_reg(32'h0000_0006);
    chk("s3_multi_dirty", dirty_o, 32'h0);
    chk("s3_multi_err", 32'(onehot_error_o), 32'd1);
    write_reg(32'h0000_0000);
    chk("s3_none_dirty", dirty_o, 32'h0);
    chk("s3_none_err", 32'(onehot_error_o), 32'd1);
    tick();
    chk("s3_sticky_err", 32'(onehot_error_o), 32'd1);
    clear_pulse();
    chk("s3_clear_err", 32'(onehot_error_o), 32'd0);
    $display("[TB] one-hot error flag checked");

    // Back-pressure on index 3, then accept with simultaneous re-write of 3
    write_reg(32'h0000_0008);
    write_reg(32'h0000_0200);
    scan_start_i = 1'b1;
    tick();
    scan_start_i = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("s4_hold%0d_valid", c), 32'(index_valid_o), 32'd1);
      chk($sformatf("s4_hold%0d_index", c), 32'(index_o), 32'd3);
      if (c < 3) tick();
    end
    index_ready_i = 1'b1;
    write_enable_i = 1'b1;
    select_register_i = 32'h0000_0008;
    tick();
    write_enable_i = 1'b0;
    select_register_i = '0;
    index_ready_i = 1'b0;
    chk("s4_keep3_dirty", dirty_o, 32'h0000_0208);
    chk("s4_search_valid", 32'(index_valid_o), 32'd0);
    tick();
    chk("s4_next_valid", 32'(index_valid_o), 32'd1);
    chk("s4_next_index", 32'(index_o), 32'd9);
    $display("[TB] scan offered index %0d", index_o);
    index_ready_i = 1'b1;
    tick();
    index_ready_i = 1'b0;
    tick();
    chk("s4_done", 32'(scan_done_o), 32'd1);
    tick();
    chk("s4_dirty_after", dirty_o, 32'h0000_0008);
    clear_pulse();

    // Writes during an offer: above pointer joins the scan, below stays dirty
    write_reg(32'h0000_0200);
    scan_start_i = 1'b1;
    tick();
    scan_start_i = 1'b0;
    tick();
    chk("s5_offer9_index", 32'(index_o), 32'd9);
    write_reg(32'h0010_0000);
    write_reg(32'h0000_0004);
    chk("s5_hold9_valid", 32'(index_valid_o), 32'd1);
    chk("s5_hold9_index", 32'(index_o), 32'd9);
    index_ready_i = 1'b1;
    tick();
    index_ready_i = 1'b0;
    tick();
    chk("s5_offer20_valid", 32'(index_valid_o), 32'd1);
    chk("s5_offer20_index", 32'(index_o), 32'd20);
    $display("[TB] scan offered index %0d", index_o);
    index_ready_i = 1'b1;
    tick();
    index_ready_i = 1'b0;
    tick();
    chk("s5_done", 32'(scan_done_o), 32'd1);
    tick();
    chk("s5_dirty_after", dirty_o, 32'h0000_0004);
    chk("s5_busy_after", 32'(scan_busy_o), 32'd0);
    clear_pulse();

    // Mid-scan clear_all_i
    write_reg(32'h0000_0010);
    write_reg(32'h0000_0080);
    scan_start_i = 1'b1;
    tick();
    scan_start_i = 1'b0;
    tick();
    chk("s6c_offer_index", 32'(index_o), 32'd4);
    clear_pulse();
    chk("s6c_busy", 32'(scan_busy_o), 32'd0);
    chk("s6c_valid", 32'(index_valid_o), 32'd0);
    chk("s6c_dirty", dirty_o, 32'h0);
    chk("s6c_done", 32'(scan_done_o), 32'd0);
    tick();
    chk("s6c_done_next", 32'(scan_done_o), 32'd0);
    $display("[TB] mid-scan clear checked");

    // Mid-scan reset
    write_reg(32'h0000_0010);
    write_reg(32'h0000_0080);
    scan_start_i = 1'b1;
    tick();
    scan_start_i = 1'b0;
    tick();
    chk("s6r_offer_valid", 32'(index_valid_o), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6r_busy", 32'(scan_busy_o), 32'd0);
    chk("s6r_valid", 32'(index_valid_o), 32'd0);
    chk("s6r_dirty", dirty_o, 32'h0);
    chk("s6r_done", 32'(scan_done_o), 32'd0);
    chk("s6r_index", 32'(index_o), 32'd0);
    tick();
    chk("s6r_done_next", 32'(scan_done_o), 32'd0);
    $display("[TB] mid-scan reset checked");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
